// File: rtl/fp_pkg.sv
// Shared floating-point definitions.
//   - Exception-flag layout {NV,DZ,OF,UF,NX} and bit indices.
//   - Rounding-mode encodings used by the FP CSR.
package fp_pkg;

  localparam int FFLAGS_W = 5;

  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  typedef logic [FFLAGS_W-1:0] fflags_t;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4,
    RM_DYN = 3'd7
  } rounding_mode_e;

endpackage

// File: rtl/fflags_fifo.sv
// Circular storage for pending exception flags.
// Ports:
//   clock, reset (synchronous, active-low)
//   push   : request to write wdata at tail (dropped when full or flushing)
//   pop    : remove head entry (caller guarantees !empty)
//   flush  : discard every entry remaining after this cycle's pop
//   wdata  : flags to store;  rdata : flags at head
//   count  : occupied entries; empty / full : registered status
module fflags_fifo
  import fp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fflags_t                  wdata,
  output fflags_t                  rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);

  fflags_t            mem [DEPTH];
  logic [PTR_W:0]     head_q, tail_q;   // index plus wrap bit
  logic [PTR_W:0]     count_q, count_nxt;
  logic               empty_q, full_q;
  logic               do_push;

  // Ready is taken from the registered full flag, so a pop in a full cycle
  // only frees a slot for the next cycle.
  assign do_push = push && !full_q && !flush;

  always_comb begin
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(pop);
  end

  // NOTE: storage holds no reset; an entry is only ever read after it was written.
  always_ff @(posedge clock) begin
    if (do_push)
      mem[tail_q[PTR_W-1:0]] <= wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      if (do_push)
        tail_q <= tail_q + 1'b1;
      // Flush jumps head to tail, which already accounts for a same-cycle pop.
      if (flush)
        head_q <= tail_q;
      else if (pop)
        head_q <= head_q + 1'b1;
      count_q <= count_nxt;
      empty_q <= (count_nxt == '0);
      full_q  <= (count_nxt == (PTR_W+1)'(DEPTH));
    end
  end

  assign rdata = mem[head_q[PTR_W-1:0]];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/fp_fflags_commit.sv
// In-order commit buffer for FP exception flags feeding the FP CSR.
// Holds flags of completed ops until retirement, then emits a one-cycle
// fflags_out/fflags_out_valid pulse (suppressed for all-zero flags).
// Optional feature macro: FFLAGS_COUNTERS_EN adds five saturating per-flag
// counters of retired flags, read through cnt_sel/cnt_rdata.
// Ports:
//   clock, reset (synchronous, active-low)
//   enq_valid/enq_flags/enq_ready : flags from the FP unit
//   retire_valid                  : oldest op retires
//   flush                         : squash all non-retired entries
//   fflags_out/fflags_out_valid   : registered pulse to the CSR
//   count/empty                   : occupancy
//   underflow_err                 : sticky retire-while-empty
//   cnt_sel/cnt_rdata             : counter readback (0 when disabled)
module fp_fflags_commit
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enq_valid,
  input  logic [FFLAGS_W-1:0]      enq_flags,
  output logic                     enq_ready,
  input  logic                     retire_valid,
  input  logic                     flush,
  output logic [FFLAGS_W-1:0]      fflags_out,
  output logic                     fflags_out_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     underflow_err,
  input  logic [2:0]               cnt_sel,
  output logic [CNT_W-1:0]         cnt_rdata
);

  fflags_t head_flags;
  logic    fifo_full;
  logic    pop;

  // An entry written this cycle is not visible yet, so a retire on an empty
  // buffer is an underflow even with a simultaneous enqueue.
  assign pop       = retire_valid && !empty;
  assign enq_ready = !fifo_full;

  fflags_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (enq_valid),
    .pop   (pop),
    .flush (flush),
    .wdata (enq_flags),
    .rdata (head_flags),
    .count (count),
    .empty (empty),
    .full  (fifo_full)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      fflags_out       <= '0;
      fflags_out_valid <= 1'b0;
      underflow_err    <= 1'b0;
    end else begin
      fflags_out       <= pop ? head_flags : '0;
      fflags_out_valid <= pop && (head_flags != '0);
      if (retire_valid && empty)
        underflow_err <= 1'b1;
    end
  end

`ifdef FFLAGS_COUNTERS_EN
  logic [CNT_W-1:0] cnt_q [FFLAGS_W];

  for (genvar g = 0; g < FFLAGS_W; g++) begin : g_cnt
    always_ff @(posedge clock) begin
      if (!reset)
        cnt_q[g] <= '0;
      else if (pop && head_flags[g] && (cnt_q[g] != '1))
        cnt_q[g] <= cnt_q[g] + 1'b1;
    end
  end

  // NOTE: default assignment first keeps this combinational block latch-free.
  always_comb begin
    cnt_rdata = '0;
    for (int i = 0; i < FFLAGS_W; i++)
      if (cnt_sel == 3'(i))
        cnt_rdata = cnt_q[i];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_rdata      = '0;
`endif

endmodule

// File: tb/tb_fp_fflags_commit.sv
// Self-checking bench for fp_fflags_commit: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// queue-based reference model.
module tb_fp_fflags_commit;
  import fp_pkg::*;

  localparam int DEPTH = 4;
`ifdef FFLAGS_COUNTERS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif
  localparam int CW = $clog2(DEPTH) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             enq_valid = 1'b0;
  logic [4:0]       enq_flags = '0;
  logic             enq_ready;
  logic             retire_valid = 1'b0;
  logic             flush = 1'b0;
  logic [4:0]       fflags_out;
  logic             fflags_out_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             underflow_err;
  logic [2:0]       cnt_sel = '0;
  logic [CNT_W-1:0] cnt_rdata;

  always #5 clock = ~clock;

  fp_fflags_commit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock            (clock),
    .reset            (reset),
    .enq_valid        (enq_valid),
    .enq_flags        (enq_flags),
    .enq_ready        (enq_ready),
    .retire_valid     (retire_valid),
    .flush            (flush),
    .fflags_out       (fflags_out),
    .fflags_out_valid (fflags_out_valid),
    .count            (count),
    .empty            (empty),
    .underflow_err    (underflow_err),
    .cnt_sel          (cnt_sel),
    .cnt_rdata        (cnt_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: pending flags in a queue, counters as plain integers.
  logic [4:0] q[$];
  bit         m_uerr;
  int         mcnt [5];

  // Expected DUT outputs after the most recent clock edge.
  bit         chk_en = 0;
  logic [4:0] exp_out;
  bit         exp_valid;
  int         exp_count;
  bit         exp_uerr;
  int         exp_cnt [5];

  function automatic int cnt_max();
    return (1 << CNT_W) - 1;
  endfunction

  task automatic publish(input logic [4:0] o, input bit v);
    exp_out   = o;
    exp_valid = v;
    exp_count = q.size();
    exp_uerr  = m_uerr;
    for (int i = 0; i < 5; i++) exp_cnt[i] = mcnt[i];
  endtask

  task automatic do_reset();
    reset = 1'b0; enq_valid = 0; retire_valid = 0; flush = 0; enq_flags = '0;
    @(posedge clock); #1;
    q.delete();
    m_uerr = 0;
    for (int i = 0; i < 5; i++) mcnt[i] = 0;
    publish(5'b0, 0);
    reset = 1'b1;
  endtask

  // Drive one cycle of inputs, advance the model, wait past the edge.
  task automatic cycle(input bit ev, input logic [4:0] ef, input bit rv,
                       input bit fl, input logic [2:0] sel = 3'd0);
    logic [4:0] n_out;
    bit         n_valid;
    bit         ready;
    logic [4:0] h;
    enq_valid = ev; enq_flags = ef; retire_valid = rv; flush = fl; cnt_sel = sel;
    ready   = (q.size() < DEPTH);
    n_out   = '0;
    n_valid = 0;
    if (rv) begin
      if (q.size() == 0) m_uerr = 1;
      else begin
        h = q.pop_front();
        n_out = h;
        n_valid = (h != 0);
        for (int i = 0; i < 5; i++)
          if (h[i] && mcnt[i] < cnt_max()) mcnt[i]++;
      end
    end
    if (fl) q.delete();
    else if (ev && ready) q.push_back(ef);
    @(posedge clock); #1;
    publish(n_out, n_valid);
  endtask

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clock) begin
    if (chk_en) begin
      int e_cnt;
`ifdef FFLAGS_COUNTERS_EN
      e_cnt = (cnt_sel < 5) ? exp_cnt[cnt_sel] : 0;
`else
      e_cnt = 0;
`endif
      check("fflags_out",       32'(fflags_out),       32'(exp_out));
      check("fflags_out_valid", 32'(fflags_out_valid), 32'(exp_valid));
      check("count",            32'(count),            32'(exp_count));
      check("empty",            32'(empty),            32'(exp_count == 0));
      check("enq_ready",        32'(enq_ready),        32'(exp_count < DEPTH));
      check("underflow_err",    32'(underflow_err),    32'(exp_uerr));
      check("cnt_rdata",        32'(cnt_rdata),        32'(e_cnt));
    end
  end

  initial begin
    do_reset();
    chk_en = 1;
    check("rst_count", 32'(count), 0);
    check("rst_empty", 32'(empty), 1);
    check("rst_ready", 32'(enq_ready), 1);
    check("rst_valid", 32'(fflags_out_valid), 0);
    check("rst_out",   32'(fflags_out), 0);
    check("rst_uerr",  32'(underflow_err), 0);

    // Single enqueue then retire.
    cycle(1, 5'b00001, 0, 0);
    check("t1_count1", 32'(count), 1);
    cycle(0, 5'b0, 1, 0);
    check("t1_out",   32'(fflags_out), 5'b00001);
    check("t1_valid", 32'(fflags_out_valid), 1);
    check("t1_count", 32'(count), 0);
    cycle(0, 5'b0, 0, 0);
    check("t1_pulse_end", 32'(fflags_out_valid), 0);
    check("t1_out_zero",  32'(fflags_out), 0);

    // Zero-flag entry produces no pulse.
    cycle(1, 5'b10000, 0, 0);
    cycle(1, 5'b00000, 0, 0);
    cycle(1, 5'b00100, 0, 0);
    cycle(0, 5'b0, 1, 0);
    check("t2_p1", 32'({fflags_out_valid, fflags_out}), 32'({1'b1, 5'b10000}));
    cycle(0, 5'b0, 1, 0);
    check("t2_p2", 32'({fflags_out_valid, fflags_out}), 32'({1'b0, 5'b00000}));
    cycle(0, 5'b0, 1, 0);
    check("t2_p3", 32'({fflags_out_valid, fflags_out}), 32'({1'b1, 5'b00100}));

    // Fill, overflow attempt, retire+enqueue while full.
    cycle(1, 5'b00010, 0, 0);
    cycle(1, 5'b00110, 0, 0);
    cycle(1, 5'b01010, 0, 0);
    cycle(1, 5'b10010, 0, 0);
    check("t3_full_ready", 32'(enq_ready), 0);
    check("t3_full_count", 32'(count), 4);
    cycle(1, 5'b11111, 0, 0);
    check("t3_ovf_count", 32'(count), 4);
    cycle(1, 5'b11111, 1, 0);
    check("t3_rf_count", 32'(count), 3);
    check("t3_rf_ready", 32'(enq_ready), 1);
    check("t3_rf_out",   32'(fflags_out), 5'b00010);
    cycle(1, 5'b00011, 0, 0);
    check("t3_refill", 32'(count), 4);
    for (int i = 0; i < 4; i++) cycle(0, 5'b0, 1, 0);
    check("t3_last_out", 32'(fflags_out), 5'b00011);
    check("t3_drained",  32'(count), 0);

    // Flush with simultaneous retire.
    cycle(1, 5'b10100, 0, 0);
    cycle(1, 5'b00001, 0, 0);
    cycle(1, 5'b00010, 0, 0);
    cycle(1, 5'b01000, 1, 1);
    check("t4_out",   32'(fflags_out), 5'b10100);
    check("t4_valid", 32'(fflags_out_valid), 1);
    check("t4_count", 32'(count), 0);
    cycle(0, 5'b0, 1, 0);
    check("t4_uerr",  32'(underflow_err), 1);
    check("t4_nopulse", 32'(fflags_out_valid), 0);

    // Retire on empty with simultaneous enqueue.
    do_reset();
    cycle(1, 5'b01000, 1, 0);
    check("t5_uerr",  32'(underflow_err), 1);
    check("t5_count", 32'(count), 1);
    check("t5_nopulse", 32'(fflags_out_valid), 0);
    cycle(0, 5'b0, 1, 0);
    check("t5_out", 32'({fflags_out_valid, fflags_out}), 32'({1'b1, 5'b01000}));

`ifdef FFLAGS_COUNTERS_EN
    do_reset();
    for (int i = 0; i < 17; i++) begin
      cycle(1, 5'b00001, 0, 0);
      cycle(0, 5'b0, 1, 0);
    end
    cycle(1, 5'b10000, 0, 0);
    cycle(0, 5'b0, 0, 1);
    cycle(0, 5'b0, 0, 0, 3'd0);
    check("t6_nx_sat", 32'(cnt_rdata), 32'hF);
    cycle(0, 5'b0, 0, 0, 3'd4);
    check("t6_nv_zero", 32'(cnt_rdata), 0);
`endif

    // Randomized traffic with occasional flush and mid-run reset.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(199) == 0) begin
        do_reset();
      end else begin
        logic [4:0] f;
        f = ($urandom_range(3) == 0) ? 5'b0 : 5'($urandom);
        cycle($urandom_range(99) < 60, f, $urandom_range(99) < 50,
              $urandom_range(99) < 4, 3'($urandom));
      end
    end

    @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_fflags_commit.md
# fp_fflags_commit

In-order commit buffer for floating-point exception flags, sitting directly upstream of the FP CSR. Holds the 5-bit `{NV,DZ,OF,UF,NX}` flags produced by each completed FP operation until the instruction retires, then drives the CSR's `fflags_in`/`fflags_valid` pair. Flushed (squashed) instructions never reach the accrued-flag register. Zero-flag retirements are suppressed to save CSR toggling.

## Interface
- `DEPTH`, 4: buffer entries; power of two, ≥2
- `CNT_W`, 16: width of the optional per-flag event counters

- `clock`  input  1  system clock, rising edge
- `reset`  input  1  synchronous, active-low reset
- `enq_valid`  input  1  FP unit offers flags for one completed op
- `enq_flags`  input  5  flags `{NV,DZ,OF,UF,NX}`
- `enq_ready`  output  1  buffer can accept; equals `!full`
- `retire_valid`  input  1  oldest FP op retires this cycle
- `flush`  input  1  discard all non-retired entries
- `fflags_out`  output  5  flags to CSR `fflags_in`
- `fflags_out_valid`  output  1  to CSR `fflags_valid`; one-cycle pulse
- `count`  output  $clog2(DEPTH)+1  occupied entries
- `empty`  output  1  `count==0`
- `underflow_err`  output  1  sticky: retire seen with buffer empty
- `cnt_sel`  input  3  counter select, 0=NX … 4=NV
- `cnt_rdata`  output  CNT_W  selected counter value

## Operation
- Circular FIFO: head/tail pointers of $clog2(DEPTH) bits plus wrap bit; pointers wrap DEPTH-1→0.
- Enqueue: `enq_valid && enq_ready` writes `enq_flags` at tail, tail+1.
- Retire: `retire_valid && !empty` pops head; if head flags ≠ 0, next cycle `fflags_out`=head flags, `fflags_out_valid`=1; if head flags = 0, no pulse.
- Retire while empty: no pop, no pulse, `underflow_err` set; cleared only by reset.
- Same-cycle enqueue + retire, non-empty, not full: both occur, `count` unchanged.
- Same-cycle enqueue + retire when empty: enqueue only; retire is an underflow (entry written this cycle is not retireable).
- Full: `enq_ready`=0; a retire that cycle does not re-enable enqueue until the next cycle (no combinational ready path).
- Flush: retire in the same cycle is processed first (head popped, pulse produced as normal); all remaining entries discarded; any same-cycle enqueue is dropped; `count`=0 next cycle.
- Reset mid-operation: buffer emptied, pending output pulse cancelled.
- Outputs when not valid: `fflags_out` holds 0.

## Timing
- Reset values: `fflags_out`=0, `fflags_out_valid`=0, `count`=0, `empty`=1, `enq_ready`=1, `underflow_err`=0, counters=0.
- Retire→CSR latency: 1 cycle (registered output); flags visible in CSR 2 cycles after retire.
- Enqueue→retireable: 1 cycle.
- Throughput: one enqueue and one retire per cycle.
- `enq_ready`, `count`, `empty` are pure register outputs.

## Configuration
- `FFLAGS_COUNTERS_EN` defined: five CNT_W-bit saturating counters, one per flag; each increments by 1 for every retired entry with that flag set (flushed entries not counted); saturate at all-ones; `cnt_rdata` = counter[`cnt_sel`], 0 for `cnt_sel`≥5.
- Undefined: no counters; `cnt_rdata` tied to 0; ports retained.

## Structure
- Shared package `fp_pkg`: flag bit indices `FLAG_NX=0, FLAG_UF=1, FLAG_OF=2, FLAG_DZ=3, FLAG_NV=4`, `FFLAGS_W=5`, rounding-mode constants.
- One sub-module: `fflags_fifo` (parameterised storage, pointers, count, flush); top adds retire pulse, error, counters.

## Test plan
- Reset, enqueue 5'b00001, retire next cycle → one cycle later `fflags_out`=5'b00001, valid=1 for exactly one cycle; `count` returns 0.
- Enqueue 5'b10000, 5'b00000, 5'b00100; three retires → pulses with 5'b10000, none, 5'b00100.
- Fill DEPTH=4 entries → `enq_ready`=0, 5th `enq_valid` ignored; retire+enqueue same cycle while full → enqueue rejected, `count`=3 then refills.
- Three entries queued, `flush` with `retire_valid` same cycle → head flags pulsed, `count`=0, following retire sets `underflow_err`=1 and produces no pulse.
- Retire on empty with simultaneous enqueue of 5'b01000 → `underflow_err`=1, `count`=1, next retire pulses 5'b01000.
- With `FFLAGS_COUNTERS_EN`, CNT_W=4: retire 17 entries with NX set → `cnt_sel`=0 reads 4'hF; flushed NV entry leaves `cnt_sel`=4 at 0.
